reg_dump_tx: RTL and testbench
==============================

# reg_dump_tx

Hardware register-dump transmitter for the RV32I core. On a start request it streams a framed snapshot of a range of architectural registers out of a UART TX pin, 8N1, so board-level runs can be checked against the expected-register `.mem` files without simulation. It sits in `top` beside the register file, reading through a dedicated read port, and drives a spare FPGA pin.

## Interface

**Parameters**

- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200); must be ≥ 1.
- `FIRST_REG`, default 0: first register index dumped.
- `LAST_REG`, default 31: last register index dumped; `FIRST_REG` ≤ `LAST_REG` ≤ 31.

**Ports**

- `clk` input 1: system clock; one clock domain.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: dump request; level-sampled only in IDLE.
- `dump_addr` output 5: register-file read address.
- `dump_data` input 32: register-file read data; combinational with `dump_addr`.
- `tx` output 1: UART serial out, idle high.
- `busy` output 1: high while a frame is in progress.
- `done` output 1: one-cycle pulse when the frame completes.

## Operation

- **Frame layout:**
  - Sync byte `0xA5`.
  - For each register N from `FIRST_REG` to `LAST_REG`: 4 data bytes, MSB first.
  - One checksum byte, the XOR of all data bytes. The sync byte is excluded.
- **Byte encoding:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Bytes are sent back-to-back with no idle gap.
- **Sequencer states:**
  - IDLE: `start`=1 → SYNC.
  - SYNC: end of byte → REG.
  - REG: after byte 3 of `LAST_REG` → CSUM.
  - CSUM: end of byte → IDLE, with `done` pulsed.
- **Bit-level states** (in the sub-module): START, DATA (bit counter 0..7), STOP.
  - Baud counter runs 0..`CLKS_PER_BIT`-1.
  - The bit advances when the counter reaches `CLKS_PER_BIT`-1.
- **Register capture:**
  - The word for register N is latched into a 32-bit hold register on the edge that ends the byte preceding N's first byte.
  - `dump_addr` = N for that entire preceding byte period.
  - Registers are not frozen across the frame. Each word is a per-register snapshot.
- **Checksum:** 8-bit accumulator, cleared on frame start, XORed with each data byte as it is loaded.
- **Reset values:** `tx`=1, `busy`=0, `done`=0, `dump_addr`=`FIRST_REG`, checksum=0, all counters 0, state IDLE.
- **Reset mid-frame:** `tx`=1 from the next cycle and the frame is abandoned; no stop bit is completed. The next `start` sends a full frame from the sync byte.
- **Start while busy:** ignored, not queued.
- **Start held high:** a new frame is accepted the first IDLE cycle after `done`.
- **x0:** transmitted as read (0).

## Timing

- `start`=1 sampled in IDLE at cycle T:
  - `busy`=1 and `tx`=0 (sync start bit) from T+1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles; each byte lasts 10·`CLKS_PER_BIT` cycles.
- Frame length is (2 + 4·(`LAST_REG`−`FIRST_REG`+1))·10·`CLKS_PER_BIT` cycles.
- At the edge ending the checksum stop bit, `busy`←0 and `done`←1 together. `done` clears after one cycle.
- `dump_data` must be valid combinationally within the same cycle as `dump_addr`. No extra read latency is tolerated.

## Structure

- Package `uart_pkg` holds:
  - `SYNC_BYTE` = 8'hA5.
  - Default `CLKS_PER_BIT`.
  - Sequencer state enum (IDLE, SYNC, REG, CSUM).
  - Bit state enum (IDLE, START, DATA, STOP).
- Sub-module `uart_tx_byte` handles the bit layer:
  - Inputs: `load` (1 cycle) and `byte_in`.
  - Outputs: `tx`, `ready`.
  - Contains the baud counter and bit FSM.
  - `ready` asserts in the last cycle of the stop bit, so the next `load` is seamless.
- `reg_dump_tx` contains the sequencer, address counter, byte index (0..3), word hold register and checksum.

## Test plan

All scenarios use `CLKS_PER_BIT`=4, with a bench UART receiver checking bit timing at mid-bit.

- **Reset:** hold `reset` 5 cycles with `start`=1 → `tx`=1, `busy`=0, `done`=0 throughout; the dump begins one cycle after `reset` drops.
- **Single register:** `FIRST_REG`=`LAST_REG`=1, x1=0x12345678 → bytes A5,12,34,56,78,08.
  - `busy` high exactly 240 cycles.
  - One `done` pulse.
- **Full dump:** x0..x31, xN=N·0x01010101 → 130 bytes, 5200 cycles, correct checksum, x0 bytes all 00.
- **Start while busy:** pulse `start` mid-frame → frame unchanged, no second frame.
- **Start held high:** keep `start`=1 → second frame begins the cycle after `done`.
- **Reset mid-frame:** assert `reset` in DATA of byte 3 → `tx`=1 next cycle, `busy`=0; a later `start` yields a complete frame beginning with A5.
- **Minimum baud:** `CLKS_PER_BIT`=1, single register → 60-cycle frame with correct bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the register-dump UART path.
package uart_pkg;

    // Marks the start of every dump frame so the host can resynchronise.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // 12 MHz system clock, 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    // Frame-level sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_REG  = 2'd2,
        S_CSUM = 2'd3
    } seq_state_t;

    // Bit-level transmitter states.
    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } bit_state_t;

    // Baud counter width; one bit minimum so CLKS_PER_BIT = 1 still elaborates.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A load accepted in IDLE or in the last cycle of the
// stop bit starts the next byte with no idle gap between bytes.
//
// state   | meaning
// --------+-----------------------------------------------
// B_IDLE  | line idle high, waiting for load
// B_START | start bit (0) on the line
// B_DATA  | data bit bit_cnt (LSB first) on the line
// B_STOP  | stop bit (1); ready in its last cycle
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       ready
);

    localparam int              CW        = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    bit_state_t    state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign ready    = (state == B_STOP) && baud_end;

    // State register; tx is registered so the pin never sees decode glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= B_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
        end
    end

    // Next-state, baud/bit counting and the line level for the next cycle.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        tx_n       = 1'b1;

        case (state)
            B_IDLE: begin
                if (load) begin
                    state_n    = B_START;
                    shreg_n    = byte_in;
                    baud_cnt_n = '0;
                end
            end
            B_START: begin
                if (baud_end) begin
                    state_n    = B_DATA;
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            B_DATA: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = B_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            B_STOP: begin
                if (baud_end) begin
                    baud_cnt_n = '0;
                    if (load) begin
                        state_n = B_START;
                        shreg_n = byte_in;
                    end else begin
                        state_n = B_IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = B_IDLE;
        endcase

        case (state_n)
            B_START: tx_n = 1'b0;
            B_DATA:  tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_dump_tx.sv
// Register-dump transmitter: streams sync byte, registers FIRST_REG..LAST_REG
// (MSB first) and an XOR checksum of the data bytes over an 8N1 UART pin.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; line idle
// S_SYNC | sync byte on the line; dump_addr points at FIRST_REG
// S_REG  | data byte byte_idx of the held word on the line
// S_CSUM | checksum byte on the line; done pulses when it completes
module reg_dump_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIRST_REG    = 0,
    parameter int LAST_REG     = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  dump_addr,
    input  logic [31:0] dump_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A  = 5'(LAST_REG);

    seq_state_t  state, state_n;
    logic [1:0]  byte_idx;
    logic [31:0] hold;
    logic [7:0]  csum;
    logic        last_word;

    logic        load;
    logic [7:0]  byte_in;
    logic        ready;

    logic        frame_start;
    logic        cap_word;
    logic        step_addr;
    logic        finish;
    logic        xor_en;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .byte_in (byte_in),
        .tx      (tx),
        .ready   (ready)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Picks the next byte for the serialiser at each byte boundary.
    always_comb begin
        state_n     = state;
        load        = 1'b0;
        byte_in     = SYNC_BYTE;
        frame_start = 1'b0;
        cap_word    = 1'b0;
        step_addr   = 1'b0;
        finish      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    load        = 1'b1;
                    byte_in     = SYNC_BYTE;
                    frame_start = 1'b1;
                    state_n     = S_SYNC;
                end
            end
            S_SYNC: begin
                if (ready) begin
                    load     = 1'b1;
                    byte_in  = dump_data[31:24];
                    cap_word = 1'b1;
                    state_n  = S_REG;
                end
            end
            S_REG: begin
                if (ready) begin
                    load = 1'b1;
                    case (byte_idx)
                        2'd0: byte_in = hold[23:16];
                        2'd1: byte_in = hold[15:8];
                        2'd2: begin
                            // Byte 3 of this word is the period preceding the
                            // next word, so the read port moves on here.
                            byte_in   = hold[7:0];
                            step_addr = 1'b1;
                        end
                        default: begin
                            if (last_word) begin
                                byte_in = csum;
                                state_n = S_CSUM;
                            end else begin
                                byte_in  = dump_data[31:24];
                                cap_word = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (ready) begin
                    finish  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        xor_en = load && (state_n == S_REG);
    end

    // Address counter, word hold, byte index, checksum and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            dump_addr <= FIRST_A;
            byte_idx  <= '0;
            hold      <= '0;
            csum      <= '0;
            last_word <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;

            if (frame_start) begin
                csum      <= '0;
                last_word <= 1'b0;
                busy      <= 1'b1;
            end else if (xor_en) begin
                csum <= csum ^ byte_in;
            end

            if (finish) begin
                busy <= 1'b0;
            end

            if (cap_word) begin
                hold     <= dump_data;
                byte_idx <= '0;
            end else if (load && (state == S_REG)) begin
                byte_idx <= byte_idx + 2'd1;
            end

            if (step_addr) begin
                last_word <= (dump_addr == LAST_A);
                dump_addr <= (dump_addr == LAST_A) ? FIRST_A : dump_addr + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: three instances (single register / full dump at 4
// clocks per bit, single register at 1 clock per bit), a mid-bit UART
// receiver and a byte scoreboard fed from a register-file model.
module tb_reg_dump_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    wire  [2:0]  tx_v;
    wire  [2:0]  busy_v;
    wire  [2:0]  done_v;
    wire  [4:0]  a0, a1, a2;
    wire  [31:0] d0, d1, d2;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    assign d0 = rf[a0];
    assign d1 = rf[a1];
    assign d2 = rf[a2];

    reg_dump_tx #(.CLKS_PER_BIT(4), .FIRST_REG(1), .LAST_REG(1)) u_single (
        .clk(clk), .reset(reset), .start(start_v[0]), .dump_addr(a0),
        .dump_data(d0), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    reg_dump_tx #(.CLKS_PER_BIT(4), .FIRST_REG(0), .LAST_REG(31)) u_full (
        .clk(clk), .reset(reset), .start(start_v[1]), .dump_addr(a1),
        .dump_data(d1), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    reg_dump_tx #(.CLKS_PER_BIT(1), .FIRST_REG(1), .LAST_REG(1)) u_fast (
        .clk(clk), .reset(reset), .start(start_v[2]), .dump_addr(a2),
        .dump_data(d2), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];

    int          mon_sel = 0;
    bit          busy_prev = 1'b0;
    int          rise_cyc = 0;
    int          busy_len = 0;
    int          done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Busy-window length and done-cycle count for the selected instance.
    always @(negedge clk) begin
        bit b;
        b = (busy_v[mon_sel] === 1'b1);
        if (b && !busy_prev) rise_cyc = cyc;
        if (!b && busy_prev) busy_len = cyc - rise_cyc;
        busy_prev = b;
        if (done_v[mon_sel] === 1'b1) done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected frame from the register-file model.
    task automatic push_frame(input int first, input int last);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int r = first; r <= last; r++) begin
            for (int k = 3; k >= 0; k--) begin
                b = rf[r][k*8 +: 8];
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        exp_q.push_back(cs);
    endtask

    // Waits (bounded) for a start bit; returns the number of cycles waited.
    task automatic wait_start(input int sel, input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx_v[sel] !== 1'b0 && waited < limit);
        chk("start_bit_seen", 32'(tx_v[sel]), 32'd0);
    endtask

    // Called at the negedge in the first cycle of a start bit; samples each
    // bit mid-way and compares every byte against the scoreboard.
    task automatic rx_frame(input int sel, input int cpb, input int nbytes, output logic [7:0] last_b);
        int cur;
        cur = 0;
        last_b = 8'h00;
        for (int k = 0; k < nbytes; k++) begin
            logic [7:0] d;
            logic [7:0] e;
            bit         frame_ok;
            d = 8'h00;
            frame_ok = 1'b1;
            for (int j = 0; j < 10; j++) begin
                int   tgt;
                logic s;
                tgt = k*10*cpb + j*cpb + cpb/2;
                repeat (tgt - cur) @(negedge clk);
                cur = tgt;
                s = tx_v[sel];
                if (j == 0) begin
                    if (s !== 1'b0) frame_ok = 1'b0;
                end else if (j == 9) begin
                    if (s !== 1'b1) frame_ok = 1'b0;
                end else begin
                    d[j-1] = s;
                end
            end
            chk($sformatf("framing_byte%0d", k), 32'(frame_ok), 32'd1);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty: got byte 0x%0h expected none", d);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("byte%0d", k), 32'(d), 32'(e));
            end
            last_b = d;
        end
    endtask

    task automatic run_frame(input int sel, input int cpb, input int first, input int last,
                             input int exp_len, input logic [7:0] exp_csum);
        int         w;
        logic [7:0] lb;
        mon_sel  = sel;
        done_cnt = 0;
        push_frame(first, last);
        start_v[sel] = 1'b1;
        wait_start(sel, 10, w);
        start_v[sel] = 1'b0;
        chk("start_to_tx_latency", 32'(w), 32'd1);
        chk("busy_in_frame", 32'(busy_v[sel]), 32'd1);
        rx_frame(sel, cpb, 2 + 4*(last - first + 1), lb);
        repeat (cpb + 3) @(negedge clk);
        chk("checksum", 32'(lb), 32'(exp_csum));
        chk("busy_len", 32'(busy_len), 32'(exp_len));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("busy_after", 32'(busy_v[sel]), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_quiet(input int sel, input int ncyc, input string name);
        bit quiet;
        quiet = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (tx_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0) quiet = 1'b0;
        end
        chk(name, 32'(quiet), 32'd1);
    endtask

    typedef struct {
        int          sel;
        int          cpb;
        int          first;
        int          last;
        logic [31:0] w1;
        bit          full;
        int          exp_len;
        logic [7:0]  exp_csum;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         w;
        int         t0;
        int         t1;
        logic [7:0] lb;

        vecs[0] = '{0, 4, 1, 1,  32'h12345678, 1'b0, 240,  8'h08};
        vecs[1] = '{0, 4, 1, 1,  32'hDEADBEEF, 1'b0, 240,  8'h22};
        vecs[2] = '{1, 4, 0, 31, 32'h00000000, 1'b1, 5200, 8'h00};
        vecs[3] = '{2, 1, 1, 1,  32'h12345678, 1'b0, 60,   8'h08};
        vecs[4] = '{2, 1, 1, 1,  32'hA5A5005A, 1'b0, 60,   8'h5A};

        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        reset   = 1'b1;
        start_v = 3'b001;

        // Reset held with start high: line idle, no status.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_tx", 32'(tx_v[0]), 32'd1);
            chk("reset_busy", 32'(busy_v[0]), 32'd0);
            chk("reset_done", 32'(done_v[0]), 32'd0);
        end
        rf[1]    = 32'h12345678;
        mon_sel  = 0;
        done_cnt = 0;
        push_frame(1, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("tx_after_reset_release", 32'(tx_v[0]), 32'd0);
        chk("busy_after_reset_release", 32'(busy_v[0]), 32'd1);
        start_v[0] = 1'b0;
        rx_frame(0, 4, 6, lb);
        repeat (7) @(negedge clk);
        chk("post_reset_busy_len", 32'(busy_len), 32'd240);
        chk("post_reset_done", 32'(done_cnt), 32'd1);

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].full) begin
                for (int n = 0; n < 32; n++) rf[n] = 32'(n) * 32'h01010101;
            end else begin
                rf[1] = vecs[v].w1;
            end
            run_frame(vecs[v].sel, vecs[v].cpb, vecs[v].first, vecs[v].last,
                      vecs[v].exp_len, vecs[v].exp_csum);
        end

        // Start pulsed mid-frame is ignored.
        rf[1]    = 32'hCAFEF00D;
        mon_sel  = 0;
        done_cnt = 0;
        push_frame(1, 1);
        start_v[0] = 1'b1;
        wait_start(0, 10, w);
        start_v[0] = 1'b0;
        fork
            begin
                repeat (100) @(negedge clk);
                start_v[0] = 1'b1;
                @(negedge clk);
                start_v[0] = 1'b0;
            end
        join_none
        rx_frame(0, 4, 6, lb);
        repeat (7) @(negedge clk);
        chk("busy_start_done", 32'(done_cnt), 32'd1);
        check_quiet(0, 60, "no_queued_frame");

        // Start held high: second frame follows the done cycle.
        rf[1]    = 32'h0F1E2D3C;
        done_cnt = 0;
        push_frame(1, 1);
        push_frame(1, 1);
        start_v[0] = 1'b1;
        wait_start(0, 10, w);
        t0 = cyc;
        rx_frame(0, 4, 6, lb);
        wait_start(0, 20, w);
        t1 = cyc;
        start_v[0] = 1'b0;
        chk("held_start_gap", 32'(t1 - t0), 32'd241);
        rx_frame(0, 4, 6, lb);
        repeat (7) @(negedge clk);
        chk("held_start_done", 32'(done_cnt), 32'd2);
        chk("held_start_queue", 32'(exp_q.size()), 32'd0);
        check_quiet(0, 40, "no_third_frame");

        // Reset during a data bit of the fourth byte (0x0F, data bit 4 = 0).
        rf[1] = 32'h55AA0FF0;
        start_v[0] = 1'b1;
        wait_start(0, 10, w);
        start_v[0] = 1'b0;
        repeat (141) @(negedge clk);
        chk("pre_reset_data_bit", 32'(tx_v[0]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("midframe_reset_tx", 32'(tx_v[0]), 32'd1);
        chk("midframe_reset_busy", 32'(busy_v[0]), 32'd0);
        chk("midframe_reset_done", 32'(done_v[0]), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_frame(0, 4, 1, 1, 240, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
